// File: rtl/xor_lane_cipher_if.sv
// Handshake and data bundle for one lane cipher: start/ack control plus the
// message, key and result words.
interface xor_lane_cipher_if #(
   parameter int DATA_BYTES = 8
);
   logic                      enable;
   logic                      mode;
   logic [8*DATA_BYTES-1:0]   message;
   logic [8*DATA_BYTES-1:0]   key;
   logic                      ack;
   logic [8*DATA_BYTES-1:0]   result;
   logic                      busy;
   logic                      done;

   modport master (
      output enable, mode, message, key, ack,
      input  result, busy, done
   );

   modport slave (
      input  enable, mode, message, key, ack,
      output result, busy, done
   );
endinterface

// File: rtl/xor_lane_cipher.sv
// Multi-round byte-lane XOR cipher: each round XORs a key-selected pad window
// into every byte and rotates the word by one byte, one round per clock.
//
// state | meaning
// IDLE  | waiting for enable; inputs captured on accept
// RUN   | one round per cycle until the remaining-round count hits zero
// DONE  | result held until ack
module xor_lane_cipher #(
   parameter int          DATA_BYTES = 8,
   parameter int          ROUNDS     = 1,
   parameter logic [63:0] PAD        = 64'hEE6B0C4F24740470
) (
   input logic              clk,
   input logic              reset,
   xor_lane_cipher_if.slave bus
);
   localparam int unsigned NB = DATA_BYTES;
   localparam int          W  = 8 * DATA_BYTES;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

   logic [1:0]   state;
   logic [W-1:0] result_q;
   logic [W-1:0] key_q;
   logic         mode_q;
   logic [7:0]   rnd;
   logic [7:0]   remain;
   logic [W-1:0] mask_r;
   logic [W-1:0] round_out;

   // Output byte i takes input byte (i - k) mod N, i.e. a left rotation by k bytes.
   function automatic logic [W-1:0] rotl_bytes(input logic [W-1:0] w, input logic [7:0] r);
      logic [W-1:0] o;
      int unsigned  k;
      k = {24'd0, r} % NB;
      o = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         o[8*i +: 8] = w[8*((i + NB - k) % NB) +: 8];
      end
      return o;
   endfunction

   function automatic logic [W-1:0] mask_of(input logic [W-1:0] k);
      logic [W-1:0] m;
      logic [7:0]   b;
      logic [2:0]   idx;
      m = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         b   = k[8*i +: 8];
         idx = {b[3] ^ b[7], b[1] ^ b[5], |(b[3:2] ^ b[7:6])};
         m[8*i +: 8] = PAD[idx +: 8];
      end
      return m;
   endfunction

   function automatic logic [W-1:0] rotl1(input logic [W-1:0] w);
      return {w[W-9:0], w[W-1:W-8]};
   endfunction

   function automatic logic [W-1:0] rotr1(input logic [W-1:0] w);
      return {w[7:0], w[W-1:8]};
   endfunction

   // Decrypt undoes the rotation before the XOR so it exactly inverts encrypt.
   always_comb begin
      mask_r    = mask_of(rotl_bytes(key_q, rnd));
      round_out = '0;
      if (mode_q) round_out = rotr1(result_q) ^ mask_r;
      else        round_out = rotl1(result_q ^ mask_r);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         result_q <= '0;
         key_q    <= '0;
         mode_q   <= 1'b0;
         rnd      <= '0;
         remain   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.enable) begin
                  result_q <= bus.message;
                  key_q    <= bus.key;
                  mode_q   <= bus.mode;
                  rnd      <= bus.mode ? LAST_RND : 8'd0;
                  remain   <= LAST_RND;
                  state    <= RUN;
               end
            end
            RUN: begin
               result_q <= round_out;
               if (remain == 8'd0) begin
                  state <= DONE;
               end else begin
                  remain <= remain - 8'd1;
                  rnd    <= mode_q ? rnd - 8'd1 : rnd + 8'd1;
               end
            end
            DONE: begin
               if (bus.ack) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == DONE);
endmodule
